// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Bus sequencing states; IDLE is revisited after every transaction.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Owner of the in-flight transaction.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// SRAM-like address/data handshake bus between the arbiter and the bus bridge.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Sequences fetch and data requests onto one shared bus, data first, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_done,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_stall,

    input  logic                 d_req,
    input  logic                 d_wr,
    input  logic [DATA_W/8-1:0]  d_wstrb,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_done,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_stall,

    mem_arbiter_if.master        bus
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;

    logic                own_q, own_d;
    logic                req_q, req_d;
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: data wins in IDLE, ADDR may skip DATA on a same-cycle data_ok.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.addr_ok) begin
                    state_d = bus.data_ok ? RESP : DATA;
                end
            end
            DATA: begin
                if (bus.data_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: next values of the bus, owner and response registers.
    always_comb begin
        own_d     = own_q;
        wr_d      = wr_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        req_d     = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;

        if (state_q == IDLE) begin
            if (d_req) begin
                own_d   = OWN_DATA;
                wr_d    = d_wr;
                wstrb_d = d_wr ? d_wstrb : STRB_W'(0);
                addr_d  = d_addr;
                wdata_d = d_wdata;
            end else if (i_req) begin
                own_d   = OWN_INST;
                wr_d    = 1'b0;
                wstrb_d = STRB_W'(0);
                addr_d  = i_addr;
            end
        end

        // RESP is only entered from ADDR/DATA on data_ok, so this is the capture cycle.
        if (state_d == RESP) begin
            if (own_q == OWN_INST) begin
                i_rdata_d = bus.rdata;
                i_done_d  = 1'b1;
            end else begin
                if (!wr_q) begin
                    d_rdata_d = bus.rdata;
                end
                d_done_d = 1'b1;
            end
        end

        req_d = (state_d == ADDR);
    end

    // Bus, owner and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q     <= OWN_INST;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= STRB_W'(0);
            addr_q    <= ADDR_W'(0);
            wdata_q   <= DATA_W'(0);
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= DATA_W'(0);
            d_rdata_q <= DATA_W'(0);
        end else begin
            own_q     <= own_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.wr    = wr_q;
    assign bus.wstrb = wstrb_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // Stalls are combinational so the hazard unit releases in the done cycle.
    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a configurable wait-state slave.
module tb_mem_arbiter;

    localparam int HMAX = 48;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;

    int n_pass;
    int n_total;

    // Slave configuration: aw_cfg ADDR cycles before addr_ok; dw_cfg DATA cycles before data_ok (-1 = with addr_ok).
    int          aw_cfg;
    int          dw_cfg;
    logic [31:0] rd_key;
    logic        spur;
    int          a_cnt;
    int          d_cnt;
    logic        acc;
    logic        s_addr_ok;
    logic        s_data_ok;

    // Expected response register contents.
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;

    // Per-cycle history recorded by run_txn.
    logic [HMAX-1:0] h_req, h_wr, h_idone, h_ddone, h_istall, h_dstall;
    logic [3:0]      h_wstrb  [HMAX];
    logic [31:0]     h_addr   [HMAX];
    logic [31:0]     h_wdata  [HMAX];
    logic [31:0]     h_irdata [HMAX];
    logic [31:0]     h_drdata [HMAX];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .i_stall (i_stall),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_wstrb (d_wstrb),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .d_stall (d_stall),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave returns address XOR key as read data; spur injects a stray data_ok.
    assign bus.addr_ok = s_addr_ok;
    assign bus.data_ok = s_data_ok | spur;
    assign bus.rdata   = spur ? 32'hDEAD_DEAD : (bus.addr ^ rd_key);

    // Slave handshake timing, updated mid-cycle for the next rising edge.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            s_addr_ok <= 1'b0;
            s_data_ok <= 1'b0;
            a_cnt     <= 0;
            d_cnt     <= 0;
            acc       <= 1'b0;
        end else begin
            s_addr_ok <= 1'b0;
            s_data_ok <= 1'b0;
            if (bus.req) begin
                if (a_cnt >= aw_cfg) begin
                    s_addr_ok <= 1'b1;
                    a_cnt     <= 0;
                    if (dw_cfg < 0) begin
                        s_data_ok <= 1'b1;
                    end else begin
                        acc   <= 1'b1;
                        d_cnt <= 0;
                    end
                end else begin
                    a_cnt <= a_cnt + 1;
                end
            end else if (acc) begin
                if (d_cnt >= dw_cfg) begin
                    s_data_ok <= 1'b1;
                    acc       <= 1'b0;
                end else begin
                    d_cnt <= d_cnt + 1;
                end
            end
        end
    end

    function automatic int first_one(input logic [HMAX-1:0] v);
        for (int k = 0; k < HMAX; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Records ncyc cycles (cycle 0 = the one in progress), drops each request after its done pulse.
    task automatic run_txn(input int ncyc, input int churn_at);
        logic drop_i;
        logic drop_d;
        h_req = '0; h_wr = '0; h_idone = '0; h_ddone = '0; h_istall = '0; h_dstall = '0;
        for (int c = 0; c < HMAX; c++) begin
            h_wstrb[c] = '0; h_addr[c] = '0; h_wdata[c] = '0; h_irdata[c] = '0; h_drdata[c] = '0;
        end
        for (int c = 0; c < ncyc && c < HMAX; c++) begin
            @(negedge clk);
            h_req[c]    = bus.req;
            h_wr[c]     = bus.wr;
            h_wstrb[c]  = bus.wstrb;
            h_addr[c]   = bus.addr;
            h_wdata[c]  = bus.wdata;
            h_idone[c]  = i_done;
            h_ddone[c]  = d_done;
            h_istall[c] = i_stall;
            h_dstall[c] = d_stall;
            h_irdata[c] = i_rdata;
            h_drdata[c] = d_rdata;
            drop_i = i_done;
            drop_d = d_done;
            @(posedge clk);
            #1;
            if (drop_i) i_req = 1'b0;
            if (drop_d) d_req = 1'b0;
            if (c + 1 == churn_at) d_addr = 32'h0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_wstrb = '0; d_addr = '0; d_wdata = '0;
        aw_cfg = 0; dw_cfg = -1; rd_key = '0; spur = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.req !== 1'b0) $display("FAIL rst_bus_req got=%b exp=0", bus.req); else n_pass++;
        n_total++; if (bus.wr !== 1'b0) $display("FAIL rst_bus_wr got=%b exp=0", bus.wr); else n_pass++;
        n_total++; if (bus.wstrb !== 4'h0) $display("FAIL rst_bus_wstrb got=%h exp=0", bus.wstrb); else n_pass++;
        n_total++; if (bus.addr !== 32'h0) $display("FAIL rst_bus_addr got=%h exp=0", bus.addr); else n_pass++;
        n_total++; if (bus.wdata !== 32'h0) $display("FAIL rst_bus_wdata got=%h exp=0", bus.wdata); else n_pass++;
        n_total++; if ({i_done, d_done} !== 2'b00) $display("FAIL rst_done got=%b exp=00", {i_done, d_done}); else n_pass++;
        n_total++; if (i_rdata !== 32'h0) $display("FAIL rst_i_rdata got=%h exp=0", i_rdata); else n_pass++;
        n_total++; if (d_rdata !== 32'h0) $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;
        run_txn(3, -1);
        n_total++; if (h_req[2:0] !== 3'b000) $display("FAIL rst_idle_req got=%b exp=000", h_req[2:0]); else n_pass++;
    endtask

    task automatic test_zero_wait_fetch();
        aw_cfg = 0; dw_cfg = -1;
        rd_key = 32'hBFC0_0000 ^ 32'h2408_0001;
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        run_txn(4, -1);
        n_total++; if (h_req[3:0] !== 4'b0010) $display("FAIL zw_req got=%b exp=0010", h_req[3:0]); else n_pass++;
        n_total++; if (h_addr[1] !== 32'hBFC0_0000) $display("FAIL zw_addr got=%h exp=bfc00000", h_addr[1]); else n_pass++;
        n_total++; if ({h_wr[1], h_wstrb[1]} !== 5'b0) $display("FAIL zw_wr_wstrb got=%b exp=00000", {h_wr[1], h_wstrb[1]}); else n_pass++;
        n_total++; if (first_one(h_idone) !== 2) $display("FAIL zw_i_done_cycle got=%0d exp=2", first_one(h_idone)); else n_pass++;
        n_total++; if ($countones(h_idone) !== 1) $display("FAIL zw_i_done_count got=%0d exp=1", $countones(h_idone)); else n_pass++;
        n_total++; if (h_irdata[2] !== 32'h2408_0001) $display("FAIL zw_i_rdata got=%h exp=24080001", h_irdata[2]); else n_pass++;
        n_total++; if (h_istall[2:0] !== 3'b011) $display("FAIL zw_i_stall got=%b exp=011", h_istall[2:0]); else n_pass++;
        n_total++; if (h_ddone !== '0) $display("FAIL zw_no_d_done got=%h exp=0", h_ddone); else n_pass++;
        exp_irdata = 32'h2408_0001;
    endtask

    task automatic test_simultaneous();
        aw_cfg = 0; dw_cfg = -1;
        rd_key = 32'h1111_2222;
        i_req = 1'b1; i_addr = 32'hBFC0_0004;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_0010; d_wstrb = 4'b0011; d_wdata = 32'h0000_BEEF;
        run_txn(7, -1);
        n_total++; if (h_req[6:0] !== 7'b0010010) $display("FAIL sim_req got=%b exp=0010010", h_req[6:0]); else n_pass++;
        n_total++; if (h_addr[1] !== 32'h8000_0010) $display("FAIL sim_store_addr got=%h exp=80000010", h_addr[1]); else n_pass++;
        n_total++; if ({h_wr[1], h_wstrb[1]} !== 5'b10011) $display("FAIL sim_store_wr_wstrb got=%b exp=10011", {h_wr[1], h_wstrb[1]}); else n_pass++;
        n_total++; if (h_wdata[1] !== 32'h0000_BEEF) $display("FAIL sim_store_wdata got=%h exp=0000beef", h_wdata[1]); else n_pass++;
        n_total++; if (h_addr[4] !== 32'hBFC0_0004) $display("FAIL sim_fetch_addr got=%h exp=bfc00004", h_addr[4]); else n_pass++;
        n_total++; if ({h_wr[4], h_wstrb[4]} !== 5'b0) $display("FAIL sim_fetch_wr_wstrb got=%b exp=00000", {h_wr[4], h_wstrb[4]}); else n_pass++;
        n_total++; if (first_one(h_ddone) !== 2) $display("FAIL sim_d_done_cycle got=%0d exp=2", first_one(h_ddone)); else n_pass++;
        n_total++; if (first_one(h_idone) !== 5) $display("FAIL sim_i_done_cycle got=%0d exp=5", first_one(h_idone)); else n_pass++;
        n_total++; if (h_drdata[2] !== exp_drdata) $display("FAIL sim_store_keeps_d_rdata got=%h exp=%h", h_drdata[2], exp_drdata); else n_pass++;
        n_total++; if (h_irdata[5] !== (32'hBFC0_0004 ^ 32'h1111_2222)) $display("FAIL sim_i_rdata got=%h exp=%h", h_irdata[5], 32'hBFC0_0004 ^ 32'h1111_2222); else n_pass++;
        exp_irdata = 32'hBFC0_0004 ^ 32'h1111_2222;
    endtask

    task automatic test_wait_states();
        aw_cfg = 2; dw_cfg = 3;
        rd_key = 32'h8000_0020 ^ 32'hCAFE_F00D;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0020; d_wstrb = 4'hF; d_wdata = 32'h5555_5555;
        run_txn(10, -1);
        n_total++; if (h_req[9:0] !== 10'b0000001110) $display("FAIL ws_req got=%b exp=0000001110", h_req[9:0]); else n_pass++;
        n_total++; if (h_wstrb[1] !== 4'h0) $display("FAIL ws_load_wstrb got=%h exp=0", h_wstrb[1]); else n_pass++;
        n_total++; if (first_one(h_ddone) !== 8) $display("FAIL ws_d_done_cycle got=%0d exp=8", first_one(h_ddone)); else n_pass++;
        n_total++; if (h_drdata[8] !== 32'hCAFE_F00D) $display("FAIL ws_d_rdata got=%h exp=cafef00d", h_drdata[8]); else n_pass++;
        n_total++; if (h_dstall[8:0] !== 9'b011111111) $display("FAIL ws_d_stall got=%b exp=011111111", h_dstall[8:0]); else n_pass++;
        exp_drdata = 32'hCAFE_F00D;
    endtask

    task automatic test_input_churn();
        aw_cfg = 0; dw_cfg = 2;
        rd_key = 32'h0F0F_0F0F;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0040; d_wstrb = 4'h0;
        run_txn(7, 3);
        n_total++; if (h_addr[3] !== 32'h8000_0040) $display("FAIL churn_addr_c3 got=%h exp=80000040", h_addr[3]); else n_pass++;
        n_total++; if (h_addr[4] !== 32'h8000_0040) $display("FAIL churn_addr_c4 got=%h exp=80000040", h_addr[4]); else n_pass++;
        n_total++; if (first_one(h_ddone) !== 5) $display("FAIL churn_d_done_cycle got=%0d exp=5", first_one(h_ddone)); else n_pass++;
        n_total++; if (h_drdata[5] !== (32'h8000_0040 ^ 32'h0F0F_0F0F)) $display("FAIL churn_d_rdata got=%h exp=%h", h_drdata[5], 32'h8000_0040 ^ 32'h0F0F_0F0F); else n_pass++;
        n_total++; if (h_irdata[5] !== exp_irdata) $display("FAIL churn_i_rdata_kept got=%h exp=%h", h_irdata[5], exp_irdata); else n_pass++;
        n_total++; if (h_idone !== '0) $display("FAIL churn_no_i_done got=%h exp=0", h_idone); else n_pass++;
        exp_drdata = 32'h8000_0040 ^ 32'h0F0F_0F0F;
    endtask

    task automatic test_spurious_data_ok();
        spur = 1'b1;
        run_txn(4, -1);
        spur = 1'b0;
        n_total++; if ((h_idone | h_ddone) !== '0) $display("FAIL spur_done got=%h exp=0", h_idone | h_ddone); else n_pass++;
        n_total++; if (h_req !== '0) $display("FAIL spur_req got=%h exp=0", h_req); else n_pass++;
        n_total++; if (h_irdata[3] !== exp_irdata) $display("FAIL spur_i_rdata got=%h exp=%h", h_irdata[3], exp_irdata); else n_pass++;
        n_total++; if (h_drdata[3] !== exp_drdata) $display("FAIL spur_d_rdata got=%h exp=%h", h_drdata[3], exp_drdata); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        aw_cfg = 0; dw_cfg = 5;
        rd_key = 32'h7777_7777;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0080;
        i_req = 1'b1; i_addr = 32'hBFC0_0010;
        run_txn(3, -1);
        rst = 1'b0;
        d_req = 1'b0;
        #1;
        n_total++; if ({bus.req, bus.wr, bus.wstrb} !== 6'b0) $display("FAIL mid_rst_req_wr_wstrb got=%b exp=0", {bus.req, bus.wr, bus.wstrb}); else n_pass++;
        n_total++; if (bus.addr !== 32'h0) $display("FAIL mid_rst_addr got=%h exp=0", bus.addr); else n_pass++;
        n_total++; if (bus.wdata !== 32'h0) $display("FAIL mid_rst_wdata got=%h exp=0", bus.wdata); else n_pass++;
        n_total++; if ({i_done, d_done} !== 2'b00) $display("FAIL mid_rst_done got=%b exp=00", {i_done, d_done}); else n_pass++;
        n_total++; if (i_rdata !== 32'h0) $display("FAIL mid_rst_i_rdata got=%h exp=0", i_rdata); else n_pass++;
        n_total++; if (d_rdata !== 32'h0) $display("FAIL mid_rst_d_rdata got=%h exp=0", d_rdata); else n_pass++;
        exp_irdata = '0;
        exp_drdata = '0;
        aw_cfg = 0; dw_cfg = -1;
        rd_key = 32'hBFC0_0010 ^ 32'h1234_5678;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_txn(4, -1);
        n_total++; if (h_req[3:0] !== 4'b0010) $display("FAIL post_rst_req got=%b exp=0010", h_req[3:0]); else n_pass++;
        n_total++; if (h_addr[1] !== 32'hBFC0_0010) $display("FAIL post_rst_addr got=%h exp=bfc00010", h_addr[1]); else n_pass++;
        n_total++; if (first_one(h_idone) !== 2) $display("FAIL post_rst_i_done_cycle got=%0d exp=2", first_one(h_idone)); else n_pass++;
        n_total++; if (h_irdata[2] !== 32'h1234_5678) $display("FAIL post_rst_i_rdata got=%h exp=12345678", h_irdata[2]); else n_pass++;
        n_total++; if (h_ddone !== '0) $display("FAIL post_rst_no_d_done got=%h exp=0", h_ddone); else n_pass++;
        exp_irdata = 32'h1234_5678;
    endtask

    // Random mixes of fetch/load/store under random slave wait states.
    task automatic test_random(input int iters);
        int          kind, lat, t1, t2, dcyc, icyc, fcyc, ntx;
        logic [31:0] ia, da, dwd, key, exp_d;
        logic [3:0]  dst, exp_strb;
        logic        dwr;
        for (int it = 0; it < iters; it++) begin
            kind   = int'($urandom_range(0, 2));
            aw_cfg = int'($urandom_range(0, 3));
            dw_cfg = int'($urandom_range(0, 4)) - 1;
            key = $urandom; ia = $urandom; da = $urandom; dwd = $urandom;
            dst = 4'($urandom); dwr = 1'($urandom);
            lat  = (dw_cfg < 0) ? 2 + aw_cfg : 3 + aw_cfg + dw_cfg;
            t1   = lat;
            t2   = 2 * lat + 1;
            dcyc = (kind != 0) ? t1 : -1;
            icyc = (kind == 0) ? t1 : ((kind == 2) ? t2 : -1);
            fcyc = (kind == 2) ? t1 + 2 : 1;
            ntx  = (kind == 2) ? 2 : 1;
            rd_key = key;
            i_req = (kind != 1); i_addr = ia;
            d_req = (kind != 0); d_addr = da; d_wr = dwr; d_wstrb = dst; d_wdata = dwd;
            run_txn(((kind == 2) ? t2 : t1) + 2, -1);

            n_total++; if (first_one(h_ddone) !== dcyc) $display("FAIL rnd%0d_d_done_cycle got=%0d exp=%0d", it, first_one(h_ddone), dcyc); else n_pass++;
            n_total++; if (first_one(h_idone) !== icyc) $display("FAIL rnd%0d_i_done_cycle got=%0d exp=%0d", it, first_one(h_idone), icyc); else n_pass++;
            n_total++; if ($countones(h_ddone | h_idone) !== ntx) $display("FAIL rnd%0d_done_count got=%0d exp=%0d", it, $countones(h_ddone | h_idone), ntx); else n_pass++;
            n_total++; if ($countones(h_req) !== ntx * (aw_cfg + 1)) $display("FAIL rnd%0d_req_cycles got=%0d exp=%0d", it, $countones(h_req), ntx * (aw_cfg + 1)); else n_pass++;

            if (kind != 0) begin
                exp_strb = dwr ? dst : 4'h0;
                exp_d    = dwr ? exp_drdata : (da ^ key);
                n_total++; if (h_addr[1] !== da) $display("FAIL rnd%0d_d_addr got=%h exp=%h", it, h_addr[1], da); else n_pass++;
                n_total++; if ({h_wr[1], h_wstrb[1]} !== {dwr, exp_strb}) $display("FAIL rnd%0d_d_wr_wstrb got=%b exp=%b", it, {h_wr[1], h_wstrb[1]}, {dwr, exp_strb}); else n_pass++;
                if (dwr) begin
                    n_total++; if (h_wdata[1] !== dwd) $display("FAIL rnd%0d_d_wdata got=%h exp=%h", it, h_wdata[1], dwd); else n_pass++;
                end
                n_total++; if (h_drdata[t1] !== exp_d) $display("FAIL rnd%0d_d_rdata got=%h exp=%h", it, h_drdata[t1], exp_d); else n_pass++;
                n_total++; if (h_dstall[t1] !== 1'b0) $display("FAIL rnd%0d_d_stall_done got=%b exp=0", it, h_dstall[t1]); else n_pass++;
                exp_drdata = exp_d;
            end
            if (kind != 1) begin
                n_total++; if (h_addr[fcyc] !== ia) $display("FAIL rnd%0d_i_addr got=%h exp=%h", it, h_addr[fcyc], ia); else n_pass++;
                n_total++; if ({h_wr[fcyc], h_wstrb[fcyc]} !== 5'b0) $display("FAIL rnd%0d_i_wr_wstrb got=%b exp=00000", it, {h_wr[fcyc], h_wstrb[fcyc]}); else n_pass++;
                n_total++; if (h_irdata[icyc] !== (ia ^ key)) $display("FAIL rnd%0d_i_rdata got=%h exp=%h", it, h_irdata[icyc], ia ^ key); else n_pass++;
                n_total++; if ({h_istall[0], h_istall[icyc]} !== 2'b10) $display("FAIL rnd%0d_i_stall got=%b exp=10", it, {h_istall[0], h_istall[icyc]}); else n_pass++;
                exp_irdata = ia ^ key;
            end else begin
                n_total++; if (h_irdata[t1] !== exp_irdata) $display("FAIL rnd%0d_i_rdata_kept got=%h exp=%h", it, h_irdata[t1], exp_irdata); else n_pass++;
            end
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_zero_wait_fetch();
        test_simultaneous();
        test_wait_states();
        test_input_churn();
        test_spurious_data_ok();
        test_reset_mid_data();
        test_random(30);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
